// File: rtl/m_axis_kernel_reorder.sv
// Ping-pong kernel buffer streaming each kernel as AXI-Stream beats in even/odd deinterleaved order.
// Optional REORDER_REVERSE_ODD_EN: kernels tagged odd are emitted in reversed beat order.
module m_axis_kernel_reorder #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned IMAGE_KERNEL_12K = 64
) (
  input  logic                                         i_clk,
  input  logic                                         i_aresetn,
  input  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]  i_image_kernel,
  input  logic                                         i_kernel_is_ready,
  input  logic                                         i_kernel_is_odd,
  output logic [DATA_WIDTH-1:0]                        o_axis_tdata,
  output logic                                         o_axis_tvalid,
  input  logic                                         i_axis_tready,
  output logic                                         o_axis_tlast,
  output logic                                         o_axis_tuser,
  output logic                                         o_overflow,
  output logic [1:0]                                   o_bank_full
);

  localparam int unsigned N  = IMAGE_KERNEL_12K;
  localparam int unsigned BW = $clog2(N);

  typedef logic [BW-1:0] beat_t;
  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nx;

  logic [0:N-1][DATA_WIDTH-1:0] bank_mem [0:1];
  logic                  wr_ptr, rd_ptr, other_ptr;
  beat_t                 beat;
  logic                  fire, last_fire, wr_free, capture;
  logic                  load_en, load_bank;
  beat_t                 load_beat, load_src;
  logic [DATA_WIDTH-1:0] load_data;
  logic [1:0]            bank_full_nx;

  // Beat k -> element 2k / 2(k-N/2)+1 is a left rotate of k by one bit.
  function automatic beat_t elem_of(input beat_t b);
    return (b << 1) | (b >> (BW - 1));
  endfunction

  always_comb begin
    other_ptr = ~rd_ptr;
    fire      = o_axis_tvalid & i_axis_tready;
    last_fire = fire & (beat == '1);
    // A bank released by the final handshake this cycle is reusable immediately.
    wr_free   = ~o_bank_full[wr_ptr] | (last_fire & (rd_ptr == wr_ptr));
    capture   = i_kernel_is_ready & wr_free;
  end

  always_comb begin
    bank_full_nx = o_bank_full;
    if (last_fire) bank_full_nx[rd_ptr] = 1'b0;
    if (capture)   bank_full_nx[wr_ptr] = 1'b1;
  end

`ifdef REORDER_REVERSE_ODD_EN
  logic bank_odd [0:1];

  always_comb load_src = bank_odd[load_bank] ? ~load_beat : load_beat;
`else
  logic unused_parity;

  always_comb unused_parity = i_kernel_is_odd;
  always_comb load_src = load_beat;
`endif

  always_comb load_data = bank_mem[load_bank][elem_of(load_src)];

  // Bank storage carries no reset.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      bank_mem[wr_ptr] <= i_image_kernel;
`ifdef REORDER_REVERSE_ODD_EN
      bank_odd[wr_ptr] <= i_kernel_is_odd;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (o_bank_full[rd_ptr]) state_nx = STREAM;
      STREAM:  if (last_fire && !o_bank_full[other_ptr]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    load_bank = rd_ptr;
    load_beat = '0;
    case (state)
      IDLE: load_en = o_bank_full[rd_ptr];
      STREAM: begin
        if (last_fire) begin
          if (o_bank_full[other_ptr]) begin
            load_en   = 1'b1;
            load_bank = other_ptr;
          end
        end else if (fire) begin
          load_en   = 1'b1;
          load_beat = beat_t'(beat + 1'b1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      beat          <= '0;
      o_bank_full   <= '0;
      o_overflow    <= 1'b0;
      o_axis_tvalid <= 1'b0;
      o_axis_tdata  <= '0;
      o_axis_tuser  <= 1'b0;
      o_axis_tlast  <= 1'b0;
    end else begin
      o_bank_full <= bank_full_nx;
      if (capture)                         wr_ptr     <= ~wr_ptr;
      if (last_fire)                       rd_ptr     <= ~rd_ptr;
      if (i_kernel_is_ready && !wr_free)   o_overflow <= 1'b1;
      if (load_en) begin
        o_axis_tvalid <= 1'b1;
        beat          <= load_beat;
        o_axis_tdata  <= load_data;
        o_axis_tuser  <= (load_beat == '0);
        o_axis_tlast  <= (load_beat == '1);
      end else if (last_fire) begin
        o_axis_tvalid <= 1'b0;
        o_axis_tuser  <= 1'b0;
        o_axis_tlast  <= 1'b0;
        beat          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_m_axis_kernel_reorder.sv
// Directed table-driven bench for m_axis_kernel_reorder (honours REORDER_REVERSE_ODD_EN).
module tb_m_axis_kernel_reorder;

  localparam int N  = 64;
  localparam int DW = 8;

  logic                   clk = 1'b0;
  logic                   i_aresetn = 1'b0;
  logic [0:N-1][DW-1:0]   i_image_kernel = '0;
  logic                   i_kernel_is_ready = 1'b0;
  logic                   i_kernel_is_odd = 1'b0;
  logic [DW-1:0]          o_axis_tdata;
  logic                   o_axis_tvalid;
  logic                   i_axis_tready = 1'b0;
  logic                   o_axis_tlast;
  logic                   o_axis_tuser;
  logic                   o_overflow;
  logic [1:0]             o_bank_full;

  m_axis_kernel_reorder #(.DATA_WIDTH(DW), .IMAGE_KERNEL_12K(N)) dut (
    .i_clk             (clk),
    .i_aresetn         (i_aresetn),
    .i_image_kernel    (i_image_kernel),
    .i_kernel_is_ready (i_kernel_is_ready),
    .i_kernel_is_odd   (i_kernel_is_odd),
    .o_axis_tdata      (o_axis_tdata),
    .o_axis_tvalid     (o_axis_tvalid),
    .i_axis_tready     (i_axis_tready),
    .o_axis_tlast      (o_axis_tlast),
    .o_axis_tuser      (o_axis_tuser),
    .o_overflow        (o_overflow),
    .o_bank_full       (o_bank_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tready;
    bit          pulse;
    bit          podd;
    int          pbase;
    bit          exp_valid;
    logic [7:0]  exp_data;
    bit          exp_user;
    bit          exp_last;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [7:0] exp_beat(input int base, input bit odd, input int k);
    int kk;
    int e;
    bit rev;
    rev = 1'b0;
`ifdef REORDER_REVERSE_ODD_EN
    rev = 1'b1;
`endif
    kk = (rev && odd) ? (N - 1 - k) : k;
    e  = (kk < N/2) ? 2*kk : 2*(kk - N/2) + 1;
    return 8'(base + e);
  endfunction

  function automatic void add_kernel(input int base, input bit odd, input bit stall);
    for (int k = 0; k < N; k++) begin
      if (stall)
        tbl.push_back('{tready:1'b0, pulse:1'b0, podd:1'b0, pbase:0, exp_valid:1'b1,
                        exp_data:exp_beat(base, odd, k), exp_user:(k == 0), exp_last:(k == N-1)});
      tbl.push_back('{tready:1'b1, pulse:1'b0, podd:1'b0, pbase:0, exp_valid:1'b1,
                      exp_data:exp_beat(base, odd, k), exp_user:(k == 0), exp_last:(k == N-1)});
    end
  endfunction

  function automatic void add_idle();
    tbl.push_back('{tready:1'b1, pulse:1'b0, podd:1'b0, pbase:0, exp_valid:1'b0,
                    exp_data:8'h00, exp_user:1'b0, exp_last:1'b0});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_kernel(input int base);
    for (int i = 0; i < N; i++) i_image_kernel[i] = 8'(base + i);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    i_aresetn         = 1'b0;
    i_kernel_is_ready = 1'b0;
    i_axis_tready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_aresetn = 1'b1;
  endtask

  task automatic pulse_kernel(input int base, input bit odd);
    set_kernel(base);
    i_kernel_is_odd   = odd;
    i_kernel_is_ready = 1'b1;
    tick();
    i_kernel_is_ready = 1'b0;
  endtask

  // Each row: drive inputs, compare registered outputs, advance one clock.
  task automatic run_table(input string tag);
    bit ok;
    for (int r = 0; r < tbl.size(); r++) begin
      i_axis_tready     = tbl[r].tready;
      i_kernel_is_ready = tbl[r].pulse;
      if (tbl[r].pulse) begin
        set_kernel(tbl[r].pbase);
        i_kernel_is_odd = tbl[r].podd;
      end
      ok = (o_axis_tvalid === tbl[r].exp_valid);
      if (tbl[r].exp_valid)
        ok = ok && (o_axis_tdata === tbl[r].exp_data) && (o_axis_tuser === tbl[r].exp_user)
                && (o_axis_tlast === tbl[r].exp_last);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s row %0d: valid=%0b data=%0h user=%0b last=%0b, expected valid=%0b data=%0h user=%0b last=%0b",
                 tag, r, o_axis_tvalid, o_axis_tdata, o_axis_tuser, o_axis_tlast,
                 tbl[r].exp_valid, tbl[r].exp_data, tbl[r].exp_user, tbl[r].exp_last);
      end
      tick();
    end
    i_kernel_is_ready = 1'b0;
    i_axis_tready     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    // Basic stream: reset state, latency, deinterleave order, tuser/tlast.
    reset_dut();
    chk("rst_tvalid", 32'(o_axis_tvalid), 0);
    chk("rst_tdata",  32'(o_axis_tdata),  0);
    chk("rst_tuser",  32'(o_axis_tuser),  0);
    chk("rst_tlast",  32'(o_axis_tlast),  0);
    chk("rst_bank_full", 32'(o_bank_full), 0);
    chk("rst_overflow",  32'(o_overflow),  0);
    i_axis_tready = 1'b1;
    pulse_kernel(0, 1'b0);
    chk("lat_cycle1_tvalid", 32'(o_axis_tvalid), 0);
    chk("lat_bank_full", 32'(o_bank_full), 32'b01);
    tick();
    chk("lat_cycle2_tvalid", 32'(o_axis_tvalid), 1);
    tbl.delete();
    add_kernel(0, 1'b0, 1'b0);
    add_idle();
    run_table("basic");
    chk("basic_bank_free", 32'(o_bank_full), 0);

    // Backpressure toggling: data/tuser/tlast held through every stall row.
    reset_dut();
    pulse_kernel(0, 1'b0);
    tick();
    tbl.delete();
    add_kernel(0, 1'b0, 1'b1);
    add_idle();
    run_table("toggle");

    // Overflow: both banks fill while stalled, third kernel is dropped.
    reset_dut();
    pulse_kernel(5, 1'b0);
    chk("ovf_full_after1", 32'(o_bank_full), 32'b01);
    repeat (63) tick();
    pulse_kernel(20, 1'b1);
    chk("ovf_full_after2", 32'(o_bank_full), 32'b11);
    chk("ovf_stall_tdata", 32'(o_axis_tdata), 5);
    chk("ovf_stall_tuser", 32'(o_axis_tuser), 1);
    chk("ovf_flag_before", 32'(o_overflow), 0);
    repeat (63) tick();
    pulse_kernel(100, 1'b0);
    chk("ovf_flag_set", 32'(o_overflow), 1);
    chk("ovf_full_after3", 32'(o_bank_full), 32'b11);
    repeat (5) tick();
    chk("ovf_flag_sticky", 32'(o_overflow), 1);
    chk("ovf_hold_tdata", 32'(o_axis_tdata), 5);
    tbl.delete();
    add_kernel(5, 1'b0, 1'b0);
    add_kernel(20, 1'b1, 1'b0);
    add_idle();
    run_table("overflow_drain");
    chk("ovf_flag_after_drain", 32'(o_overflow), 1);
    chk("ovf_banks_empty", 32'(o_bank_full), 0);

    // Back-to-back kernels: 128 beats without a bubble; second kernel is odd.
    reset_dut();
    chk("b2b_overflow_cleared", 32'(o_overflow), 0);
    i_axis_tready = 1'b1;
    set_kernel(0);
    i_kernel_is_odd   = 1'b0;
    i_kernel_is_ready = 1'b1;
    tick();
    set_kernel(128);
    i_kernel_is_odd = 1'b1;
    tick();
    i_kernel_is_ready = 1'b0;
    tbl.delete();
    add_kernel(0, 1'b0, 1'b0);
    add_kernel(128, 1'b1, 1'b0);
    add_idle();
    run_table("back_to_back");

    // Ready pulse on the final-beat handshake while both banks are full.
    reset_dut();
    pulse_kernel(0, 1'b0);
    pulse_kernel(60, 1'b1);
    chk("reuse_full", 32'(o_bank_full), 32'b11);
    tbl.delete();
    add_kernel(0, 1'b0, 1'b0);
    add_kernel(60, 1'b1, 1'b0);
    add_kernel(120, 1'b0, 1'b0);
    add_idle();
    tbl[N-1].pulse = 1'b1;
    tbl[N-1].podd  = 1'b0;
    tbl[N-1].pbase = 120;
    run_table("reuse_freed_bank");
    chk("reuse_no_overflow", 32'(o_overflow), 0);
    chk("reuse_banks_empty", 32'(o_bank_full), 0);

    // Reset in the middle of a kernel.
    reset_dut();
    i_axis_tready = 1'b1;
    pulse_kernel(0, 1'b0);
    tick();
    repeat (20) tick();
    chk("midrst_at_beat20", 32'(o_axis_tdata), 32'(exp_beat(0, 1'b0, 20)));
    #3;
    i_aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(o_axis_tvalid), 0);
    chk("midrst_tdata",  32'(o_axis_tdata),  0);
    chk("midrst_tuser",  32'(o_axis_tuser),  0);
    chk("midrst_tlast",  32'(o_axis_tlast),  0);
    chk("midrst_bank_full", 32'(o_bank_full), 0);
    tick();
    i_aresetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_axis_tvalid) seen++;
    end
    chk("midrst_no_partial_beats", 32'(seen), 0);
    pulse_kernel(7, 1'b0);
    chk("midrst_new_c1_tvalid", 32'(o_axis_tvalid), 0);
    tick();
    chk("midrst_new_tvalid", 32'(o_axis_tvalid), 1);
    chk("midrst_new_tdata",  32'(o_axis_tdata),  7);
    chk("midrst_new_tuser",  32'(o_axis_tuser),  1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
